// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-port UART transmit arbiter.
// Imported by the arbiter top and its lock timer.
package uart_arb_pkg;

    // Encoding chosen so the owning states equal their one-hot grant value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_e;

    localparam int unsigned PORT_A = 0;
    localparam int unsigned PORT_B = 1;

    localparam int unsigned DEFAULT_LOCK_TIMEOUT = 1000;

    function automatic logic [1:0] state_to_grant(input arb_state_e s);
        case (s)
            OWN_A:   return 2'b01;
            OWN_B:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/uart_arb_lock_timer.sv
// Saturating idle-cycle counter for a held lock; flags expiry in the cycle
// that brings the idle count up to TIMEOUT.
module uart_arb_lock_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the idle cycles already elapsed, so the current one makes TIMEOUT.
    assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte-send ports onto one UART data write interface,
// with alternating priority and an optional per-port lock with idle timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_we,
    input  logic [7:0]  a_di,
    input  logic        a_lock,
    output logic        a_ack,
    input  logic        b_we,
    input  logic [7:0]  b_di,
    input  logic        b_lock,
    output logic        b_ack,
    output logic        uart_dat_we,
    output logic [31:0] uart_dat_di,
    input  logic        uart_dat_wait,
    output logic [1:0]  grant
);

    arb_state_e r_state, w_state_nxt;
    logic       r_ptr, w_ptr_nxt;
    logic       w_own_we, w_own_lock, w_accept;
    logic [7:0] w_own_di;
    logic       w_tmr_en, w_tmr_clr, w_expired;

    always_comb begin
        w_own_we   = 1'b0;
        w_own_lock = 1'b0;
        w_own_di   = 8'h00;
        if (r_state == OWN_A) begin
            w_own_we   = a_we;
            w_own_lock = a_lock;
            w_own_di   = a_di;
        end else if (r_state == OWN_B) begin
            w_own_we   = b_we;
            w_own_lock = b_lock;
            w_own_di   = b_di;
        end
        w_accept = w_own_we && !uart_dat_wait;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (a_we && (!b_we || r_ptr == 1'(PORT_A))) begin
                    w_state_nxt = OWN_A;
                end else if (b_we) begin
                    w_state_nxt = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if ((!w_own_lock && (w_accept || !w_own_we)) || w_expired) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = (r_state == OWN_A) ? 1'(PORT_B) : 1'(PORT_A);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_ptr   <= 1'(PORT_A);
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign w_tmr_en  = (r_state != IDLE) && !w_own_we;
    assign w_tmr_clr = !w_tmr_en || (w_state_nxt != r_state);

    uart_arb_lock_timer #(
        .TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_timer (
        .clk       (clk),
        .resetn    (resetn),
        .i_en      (w_tmr_en),
        .i_clr     (w_tmr_clr),
        .o_expired (w_expired)
    );

    // Outputs are qualified by resetn so nothing is granted or acked while reset is held.
    always_comb begin
        grant       = resetn ? state_to_grant(r_state) : 2'b00;
        uart_dat_we = resetn && w_own_we;
        uart_dat_di = (resetn && r_state != IDLE) ? {24'h000000, w_own_di} : 32'h0;
        a_ack       = resetn && (r_state == OWN_A) && a_we && !uart_dat_wait;
        b_ack       = resetn && (r_state == OWN_B) && b_we && !uart_dat_wait;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: LOCK_TIMEOUT, 1000, consecutive idle cycles after which a held lock is revoked.
REQ-002 Clock and reset: reset resetn, synchronous, active-low; clock clk.
REQ-003 clk  input  1  system clock.
REQ-004 resetn  input  1  synchronous active-low reset.
REQ-005 a_we  input  1  port A byte-send request; held until a_ack.
REQ-006 a_di  input  8  port A byte; held stable with a_we.
REQ-007 a_lock  input  1  port A asks to keep the grant across bytes.
REQ-008 a_ack  output  1  one-cycle pulse: port A byte accepted by the UART.
REQ-009 b_we, b_di, b_lock, b_ack  same widths and directions as the port A signals  port B equivalents.
REQ-010 uart_dat_we  output  1  UART data write strobe.
REQ-011 uart_dat_di  output  32  UART write data, {24'b0, byte}.
REQ-012 uart_dat_wait  input  1  UART busy; a write is accepted only when uart_dat_we && !uart_dat_wait.
REQ-013 grant  output  2  one-hot current owner: bit0 = A, bit1 = B, 00 = idle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN_A, OWN_B.
REQ-015 IDLE: if exactly one of a_we/b_we is high, the FSM SHALL move to that port's OWN state on the next edge.
REQ-016 IDLE: if a_we and b_we are both high, the FSM SHALL grant the port selected by the 1-bit priority pointer.
REQ-017 uart_dat_we SHALL be 0 in IDLE.
REQ-018 In OWN_x, uart_dat_we SHALL be x_we and uart_dat_di SHALL be {24'b0, x_di}, both combinational.
REQ-019 x_ack SHALL equal OWN_x && x_we && !uart_dat_wait (combinational, same cycle as the UART write).
REQ-020 The non-owning port's ack SHALL stay 0, and its request SHALL stay pending without being dropped.
REQ-021 Latency: the first uart_dat_we SHALL occur one cycle after the request is seen in IDLE.
REQ-022 OWN_x after an ack with x_lock = 0: the FSM SHALL return to IDLE, and the pointer SHALL point to the other port.
REQ-023 OWN_x after an ack with x_lock = 1: the FSM SHALL stay in OWN_x.
REQ-024 OWN_x with x_we = 0 and x_lock = 0: the FSM SHALL go to IDLE next cycle, with the pointer set to the other port.
REQ-025 Lock timer: it SHALL count cycles in OWN_x with x_we = 0 and clear on any x_we = 1 or on a state change.
REQ-026 Lock timer expiry: when the count reaches LOCK_TIMEOUT, the FSM SHALL force IDLE even if x_lock = 1, with the pointer set to the other port.
REQ-027 The lock timer SHALL saturate; it SHALL NOT wrap.
REQ-028 If uart_dat_wait stays high, the arbiter SHALL hold OWN_x indefinitely, and the timer SHALL NOT count while x_we = 1.
REQ-029 A lock raised while in IDLE SHALL have no effect until that port is granted.
REQ-030 The arbiter SHALL never issue two UART writes in one cycle, and grant SHALL never be 11.

Reset
REQ-031 While resetn is low at an edge: state IDLE, pointer to port A, lock timer 0.
REQ-032 Outputs under reset: grant = 00, uart_dat_we = 0, uart_dat_di = 0, a_ack = b_ack = 0.
REQ-033 Reset mid-grant SHALL drop ownership at that edge; the arbiter SHALL NOT produce an ack during reset.

Structure
REQ-034 Shared package uart_arb_pkg SHALL hold the state enum, the PORT_A/PORT_B index constants and the LOCK_TIMEOUT default.
REQ-035 The lock timer SHALL be sub-module uart_arb_lock_timer: count enable, clear, saturating expiry flag.

Verification
REQ-036 Single request: a_we = 1, a_di = 8'h41, uart_dat_wait = 0 -> uart_dat_we one cycle after request, uart_dat_di = 32'h41, a_ack pulse, then IDLE.
REQ-037 Simultaneous requests after reset: a_we = b_we = 1 -> A served first, then B; next simultaneous pair -> A again (pointer alternates).
REQ-038 Locked burst: a_lock = 1 while A sends 3 bytes, with b_we = 1 throughout -> 3 consecutive A acks before any b_ack.
REQ-039 Lock timeout with LOCK_TIMEOUT = 8: A holds lock with a_we = 0 -> grant drops to 00 after 8 idle cycles, then B is granted.
REQ-040 Busy UART: uart_dat_wait = 1 for 50 cycles -> uart_dat_we held, no ack, data stable; ack in the first cycle wait falls.
REQ-041 Reset mid-grant: resetn low while OWN_B -> grant = 00, no ack; after release, a pending a_we is served first.
